noc_rx_port: RTL and testbench

- Clocked ejection port between a torus NoC node output and the local consumer (memory wrapper or PE).
- Accepts 39-bit packets over a 4-phase bundled-data req/ack handshake.
- Checks the destination address, drops misaddressed packets, and buffers accepted ones in a first-word-fall-through FIFO.
- Presents the decoded header/payload fields on a valid/ready interface.

---
 rtl/noc_rx_port.sv | 116 +++++++++++
 tb/tb_noc_rx_port.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_rx_port.sv
// noc_rx_port: torus NoC ejection port with a 4-phase req/ack receiver,
// destination filtering and a first-word-fall-through FIFO.
module noc_rx_port #(
  parameter int DEPTH  = 4,
  parameter int NODE_X = 0,
  parameter int NODE_Y = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_req,
  output logic                         in_ack,
  input  logic [38:0]                  in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3:0]                   out_src,
  output logic [2:0]                   out_type,
  output logic [27:0]                  out_payload,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [7:0]                   drop_cnt,
  output logic                         drop_pulse
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    RX_IDLE,
    RX_ACK
  } rx_state_e;

  rx_state_e         state_q, state_d;
  logic              ack_q, ack_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic              drop_pulse_q, drop_pulse_d;

  // Address bits are consumed by the filter, so only src/type/payload are stored.
  logic [34:0]       mem_q [DEPTH];

  logic match, full, idle_req, push, drop, pop;

  always_comb begin
    match    = (in_data[38:37] == 2'(NODE_X)) &&
               (in_data[36:35] == 2'(NODE_Y));
    full     = (count_q == CNT_W'(DEPTH));
    idle_req = (state_q == RX_IDLE) && in_req;
    push     = idle_req && match && !full;
    drop     = idle_req && !match;
    pop      = (count_q != '0) && out_ready;

    state_d = state_q;
    ack_d   = ack_q;
    unique case (state_q)
      RX_IDLE: begin
        if (push || drop) begin
          state_d = RX_ACK;
          ack_d   = 1'b1;
        end
      end
      RX_ACK: begin
        if (!in_req) begin
          state_d = RX_IDLE;
          ack_d   = 1'b0;
        end
      end
    endcase

    drop_pulse_d = drop;
    drop_cnt_d   = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RX_IDLE;
      ack_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data[34:0];
    end
  end

  assign in_ack      = ack_q;
  assign out_valid   = (count_q != '0);
  assign out_src     = mem_q[rd_ptr_q][34:31];
  assign out_type    = mem_q[rd_ptr_q][30:28];
  assign out_payload = mem_q[rd_ptr_q][27:0];
  assign count       = count_q;
  assign drop_cnt    = drop_cnt_q;
  assign drop_pulse  = drop_pulse_q;

endmodule

// File: tb/tb_noc_rx_port.sv
// tb_noc_rx_port: scoreboard bench for noc_rx_port at node (1,2), DEPTH=4.
// Accepted packets are queued on drive and checked when the consumer pops.
module tb_noc_rx_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_req = 1'b0;
  logic        in_ack;
  logic [38:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_src;
  logic [2:0]  out_type;
  logic [27:0] out_payload;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;
  logic        drop_pulse;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int max_count = 0;
  logic [34:0] exp_q[$];

  noc_rx_port #(.DEPTH(4), .NODE_X(1), .NODE_Y(2)) dut (
    .clk(clk), .rst(rst),
    .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .out_type(out_type),
    .out_payload(out_payload), .count(count),
    .drop_cnt(drop_cnt), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  // Inputs only change at posedge+1, so a negedge handshake implies a pop.
  always @(negedge clk) begin
    if (!rst) begin
      if (drop_pulse === 1'b1) pulses++;
      if (int'(count) > max_count) max_count = int'(count);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        logic [34:0] got;
        logic [34:0] exp;
        got = {out_src, out_type, out_payload};
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL pop_unexpected: got %h, none queued", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            fails++;
            $display("FAIL pop_data: got %h, exp %h", got, exp);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [38:0] pkt(input logic [1:0] dx,
                                      input logic [1:0] dy,
                                      input logic [3:0] s,
                                      input logic [2:0] t,
                                      input logic [27:0] p);
    return {dx, dy, s, t, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_up(input logic [38:0] d);
    in_data = d;
    in_req  = 1'b1;
    if (d[38:35] == 4'b0110) exp_q.push_back(d[34:0]);
  endtask

  task automatic wait_ack(input logic lvl, input int max, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (in_ack !== lvl && lat < max);
    if (in_ack !== lvl) lat = -1;
  endtask

  task automatic handshake(input logic [38:0] d, output int up, output int dn);
    req_up(d);
    wait_ack(1'b1, 20, up);
    in_req = 1'b0;
    wait_ack(1'b0, 20, dn);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests++;
    if (in_ack !== 1'b0 || out_valid !== 1'b0 || count !== 3'd0 ||
        drop_cnt !== 8'd0 || drop_pulse !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: ack=%b vld=%b cnt=%0d drop=%0d pulse=%b, exp all 0",
               in_ack, out_valid, count, drop_cnt, drop_pulse);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int up, dn;
    out_ready = 1'b1;
    req_up(pkt(2'd1, 2'd2, 4'h5, 3'b010, 28'h0ABCDEF));
    wait_ack(1'b1, 20, up);
    tests++;
    if (up !== 1) begin
      fails++;
      $display("FAIL single_ack_rise: latency %0d, exp 1", up);
    end
    tests++;
    if (out_valid !== 1'b1 || out_src !== 4'h5 || out_type !== 3'd2 ||
        out_payload !== 28'h0ABCDEF) begin
      fails++;
      $display("FAIL single_fields: vld=%b src=%h type=%h pay=%h, exp 1/5/2/0abcdef",
               out_valid, out_src, out_type, out_payload);
    end
    in_req = 1'b0;
    wait_ack(1'b0, 20, dn);
    tests++;
    if (dn !== 1) begin
      fails++;
      $display("FAIL single_ack_fall: latency %0d, exp 1", dn);
    end
    tests++;
    if (count !== 3'd0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL single_drain: count=%0d queued=%0d, exp 0/0", count, exp_q.size());
    end
  endtask

  task automatic test_drop();
    int up, dn, p0;
    p0 = pulses;
    handshake(pkt(2'd3, 2'd3, 4'h1, 3'd0, 28'h1234567), up, dn);
    tick();
    tests++;
    if (up !== 1 || dn !== 1) begin
      fails++;
      $display("FAIL drop_handshake: up=%0d dn=%0d, exp 1/1", up, dn);
    end
    tests++;
    if (pulses - p0 != 1 || drop_cnt !== 8'd1) begin
      fails++;
      $display("FAIL drop_count: pulses=%0d cnt=%0d, exp 1/1", pulses - p0, drop_cnt);
    end
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL drop_valid: out_valid=%b, exp 0", out_valid);
    end
  endtask

  task automatic test_full();
    int up, dn, lat;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      handshake(pkt(2'd1, 2'd2, 4'h3, 3'd1, 28'(i)), up, dn);
    end
    tests++;
    if (count !== 3'd4) begin
      fails++;
      $display("FAIL full_count: count=%0d, exp 4", count);
    end
    req_up(pkt(2'd1, 2'd2, 4'h3, 3'd1, 28'd5));
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (in_ack !== 1'b0) begin
        fails++;
        $display("FAIL full_backpressure: in_ack=%b cycle %0d, exp 0", in_ack, i);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if (in_ack !== 1'b0 || count !== 3'd3) begin
      fails++;
      $display("FAIL full_pop_edge: ack=%b count=%0d, exp 0/3", in_ack, count);
    end
    tick();
    tests++;
    if (in_ack !== 1'b1 || count !== 3'd4) begin
      fails++;
      $display("FAIL full_refill: ack=%b count=%0d, exp 1/4", in_ack, count);
    end
    in_req = 1'b0;
    wait_ack(1'b0, 20, lat);
    out_ready = 1'b1;
    lat = 0;
    while (count !== 3'd0 && lat < 20) begin
      tick();
      lat++;
    end
    tests++;
    if (count !== 3'd0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL full_drain: count=%0d queued=%0d, exp 0/0", count, exp_q.size());
    end
  endtask

  task automatic test_saturation();
    int up, dn, p0, bad;
    p0 = pulses;
    bad = 0;
    for (int i = 0; i < 260; i++) begin
      handshake(pkt(2'd0, 2'd2, 4'h0, 3'd0, 28'(i)), up, dn);
      if (up !== 1 || dn !== 1) bad++;
    end
    tick();
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL sat_handshake: %0d slow handshakes, exp 0", bad);
    end
    tests++;
    if (drop_cnt !== 8'd255 || pulses - p0 != 260) begin
      fails++;
      $display("FAIL sat_count: cnt=%0d pulses=%0d, exp 255/260", drop_cnt, pulses - p0);
    end
  endtask

  task automatic test_stream();
    int up, dn, bad;
    out_ready = 1'b1;
    max_count = 0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      handshake(pkt(2'd1, 2'd2, 4'(i), 3'(i), 28'(i)), up, dn);
      if (up !== 1 || dn !== 1) bad++;
    end
    tick();
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stream_handshake: %0d slow handshakes, exp 0", bad);
    end
    tests++;
    if (max_count > 1) begin
      fails++;
      $display("FAIL stream_max_count: max=%0d, exp <=1", max_count);
    end
    tests++;
    if (count !== 3'd0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL stream_drain: count=%0d queued=%0d, exp 0/0", count, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int up, dn;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      handshake(pkt(2'd1, 2'd2, 4'h9, 3'd3, 28'h100 + 28'(i)), up, dn);
    end
    req_up(pkt(2'd1, 2'd2, 4'h9, 3'd3, 28'h102));
    wait_ack(1'b1, 20, up);
    tests++;
    if (in_ack !== 1'b1 || count !== 3'd3) begin
      fails++;
      $display("FAIL rmid_setup: ack=%b count=%0d, exp 1/3", in_ack, count);
    end
    rst = 1'b1;
    in_req = 1'b0;
    tick();
    tests++;
    if (in_ack !== 1'b0 || count !== 3'd0 || out_valid !== 1'b0 ||
        drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL rmid_state: ack=%b cnt=%0d vld=%b drop=%0d, exp 0/0/0/0",
               in_ack, count, out_valid, drop_cnt);
    end
    exp_q.delete();
    rst = 1'b0;
    tick();
    out_ready = 1'b1;
    handshake(pkt(2'd1, 2'd2, 4'hA, 3'd7, 28'h0FEDCBA), up, dn);
    tick();
    tests++;
    if (up !== 1 || dn !== 1 || count !== 3'd0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL rmid_fresh: up=%0d dn=%0d cnt=%0d queued=%0d, exp 1/1/0/0",
               up, dn, count, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_drop();
    test_full();
    test_saturation();
    test_stream();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
